// File: rtl/prog_counter_pkg.sv
// ---------------------------------------------------------------------------
// prog_counter_pkg
// Shared definitions for the programmable modulo counter family and for the
// timer blocks built on top of it.
//   W_MAX       : widest counter/modulus supported by the family
//   count_dir_e : decode of the one-bit direction input
//   clamp_mod   : modulus sanitisation (a zero modulus is stored as 1)
// ---------------------------------------------------------------------------
package prog_counter_pkg;

  localparam int W_MAX = 16;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  // A modulus of zero has no meaning; treat it as modulus 1 so that
  // m_reg-1 can never underflow.
  function automatic logic [W_MAX-1:0] clamp_mod(input logic [W_MAX-1:0] m);
    logic [W_MAX-1:0] res;
    if (m == {W_MAX{1'b0}}) begin
      res = {{(W_MAX-1){1'b0}}, 1'b1};
    end else begin
      res = m;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
// Divides the count enable by PRESCALE: tick is high on every PRESCALE-th
// enabled cycle. Only built when PROG_MOD_COUNTER_PRESCALE_EN is defined.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   en    : advance the internal count
//   sclr  : synchronous clear of the internal count
//   tick  : en & (count == PRESCALE-1), combinational
// ---------------------------------------------------------------------------
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ZERO = PW'(0);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pre_cnt_r;
  logic [PW-1:0] pre_cnt_next_s;

  assign tick = en & (pre_cnt_r == LAST);

  // Next value of the prescale count: clear wins, then wrap on tick.
  always_comb begin
    pre_cnt_next_s = pre_cnt_r;
    if (sclr) begin
      pre_cnt_next_s = ZERO;
    end else if (tick) begin
      pre_cnt_next_s = ZERO;
    end else if (en) begin
      pre_cnt_next_s = pre_cnt_r + ONE;
    end else begin
      pre_cnt_next_s = pre_cnt_r;
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_r <= ZERO;
    end else begin
      pre_cnt_r <= pre_cnt_next_s;
    end
  end

endmodule
`endif

// File: rtl/prog_mod_counter.sv
// ---------------------------------------------------------------------------
// prog_mod_counter
// Runtime-programmable up/down modulo counter with clear, parallel load,
// writable modulus and a cascadable carry/borrow output.
// Optional prescaler: define PROG_MOD_COUNTER_PRESCALE_EN to add the
// PRESCALE parameter and gate each count step by a tick_prescaler.
//   clk      : clock
//   reset    : asynchronous, active-high reset
//   en       : count enable
//   up       : 1 = increment, 0 = decrement
//   clr      : synchronous clear of q (and prescaler)
//   load     : synchronous load of d (clamped to m_reg-1)
//   d        : load value
//   m_wr     : write m_in into the modulus register
//   m_in     : new modulus (0 is stored as 1)
//   q        : count value, registered
//   max_tick : q == m_reg-1
//   min_tick : q == 0
//   co       : carry/borrow, high when a step wraps
// ---------------------------------------------------------------------------
module prog_mod_counter
  import prog_counter_pkg::*;
#(
  parameter int W       = 8,
  parameter int M_RESET = 10
`ifdef PROG_MOD_COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         m_wr,
  input  logic [W-1:0] m_in,
  output logic [W-1:0] q,
  output logic         max_tick,
  output logic         min_tick,
  output logic         co
);

  localparam logic [W-1:0] ZERO_W    = W'(0);
  localparam logic [W-1:0] ONE_W     = W'(1);
  localparam logic [W-1:0] M_RESET_W = W'(M_RESET);

  logic [W-1:0] q_r;
  logic [W-1:0] m_reg_r;
  logic [W-1:0] q_next_s;
  logic [W-1:0] m_next_s;
  logic [W-1:0] m_last_s;
  logic         wrap_s;
  logic         step_s;
  count_dir_e   dir_s;

  assign dir_s    = count_dir_e'(up);
  assign m_last_s = m_reg_r - ONE_W;

`ifdef PROG_MOD_COUNTER_PRESCALE_EN
  logic pre_tick_s;
  logic pre_sclr_s;

  assign pre_sclr_s = clr | load;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .sclr  (pre_sclr_s),
    .tick  (pre_tick_s)
  );

  assign step_s = en & pre_tick_s;
`else
  assign step_s = en;
`endif

  // Wrap detection. Counting down also wraps from an out-of-range q
  // (left behind by a modulus shrink) so the counter self-corrects.
  always_comb begin
    wrap_s = 1'b0;
    case (dir_s)
      DIR_UP:   wrap_s = (q_r >= m_last_s);
      DIR_DOWN: wrap_s = (q_r == ZERO_W) || (q_r >= m_reg_r);
      default:  wrap_s = 1'b0;
    endcase
  end

  // Count next-state: clear, then load, then step, else hold.
  always_comb begin
    q_next_s = q_r;
    if (clr) begin
      q_next_s = ZERO_W;
    end else if (load) begin
      if (d < m_reg_r) begin
        q_next_s = d;
      end else begin
        q_next_s = m_last_s;
      end
    end else if (step_s) begin
      case (dir_s)
        DIR_UP:   q_next_s = wrap_s ? ZERO_W : (q_r + ONE_W);
        DIR_DOWN: q_next_s = wrap_s ? m_last_s : (q_r - ONE_W);
        default:  q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // Modulus next-state; a write only takes effect from the next cycle.
  always_comb begin
    m_next_s = m_reg_r;
    if (m_wr) begin
      m_next_s = W'(clamp_mod(W_MAX'(m_in)));
    end else begin
      m_next_s = m_reg_r;
    end
  end

  // Count and modulus registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r     <= ZERO_W;
      m_reg_r <= M_RESET_W;
    end else begin
      q_r     <= q_next_s;
      m_reg_r <= m_next_s;
    end
  end

  assign q        = q_r;
  assign max_tick = (q_r == m_last_s);
  assign min_tick = (q_r == ZERO_W);
  assign co       = step_s & ~clr & ~load & wrap_s;

endmodule

// File: doc/prog_mod_counter.md
# prog_mod_counter

Runtime-programmable modulo counter: the next-generation replacement for the fixed-modulus counter, adding up/down direction, count enable, synchronous clear, parallel load, a software-writable modulus and a cascadable carry/borrow output. It sits in timer, baud-rate and display-scan paths wherever a divide ratio must change without resynthesis. Instances chain by driving the next stage's `en` from `co`.

## Interface
- `W`, 8: counter and modulus width; legal 2..16
- `M_RESET`, 10: modulus loaded into `m_reg` on reset; legal 1..2^W-1
- `PRESCALE`, 4: enabled cycles per count step; only present with the macro; legal ≥1
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  count enable
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `clr`  in  1  synchronous clear of `q` (and prescaler)
- `load`  in  1  synchronous parallel load of `d`
- `d`  in  W  load value
- `m_wr`  in  1  write `m_in` into the modulus register
- `m_in`  in  W  new modulus
- `q`  out  W  count value, registered
- `max_tick`  out  1  `q == m_reg-1`, combinational
- `min_tick`  out  1  `q == 0`, combinational
- `co`  out  1  carry/borrow: `step` active and this step wraps, combinational

## Operation
- `step` = `en` (without macro) or `en & pre_tick` (with macro).
- `q` next-state priority: `clr` → 0; else `load` → `d` if `d < m_reg`, else `m_reg-1`; else `step & up` → 0 if `q >= m_reg-1`, else `q+1`; else `step & !up` → `m_reg-1` if `q == 0` or `q >= m_reg`, else `q-1`; else hold.
- `co` = `step & !clr & !load & (up ? q >= m_reg-1 : (q == 0 || q >= m_reg))`.
- Modulus register: on `m_wr`, `m_reg <= (m_in == 0) ? 1 : m_in`. `q` is not altered by a modulus write. An out-of-range `q` self-corrects on the next step by the rules above.
- Modulus 1: `q` stays 0, `max_tick` and `min_tick` are both 1, and `co` fires on every step.
- All arithmetic is unsigned W-bit. `m_reg-1` is never negative because `m_reg >= 1`.

## Timing
- Reset (async assert, sync release): `q`=0, `m_reg`=`M_RESET`, prescaler=0.
- Outputs after reset: `max_tick` = (`M_RESET`==1), `min_tick`=1, `co`=0.
- `q` updates on the rising edge following the qualifying input. Latency is 1 cycle for clear, load and step.
- A `m_wr` in the same cycle as a step or load: that step or load uses the old `m_reg`. The new modulus is effective from the next cycle.
- `clr` and `load` are honoured regardless of `en`. `co` is suppressed in those cycles.
- Direction changes take effect on the same cycle's step. There is no pipeline.
- Reset asserted mid-count: immediate return to reset values, with no `co` pulse.

## Configuration
- Macro `PROG_MOD_COUNTER_PRESCALE_EN`.
- Defined: `tick_prescaler` is instantiated.
  - Its internal counter, `$clog2(PRESCALE)` bits (minimum 1), advances on `en`. `pre_tick` = `en & pre_cnt == PRESCALE-1`, and `pre_cnt` then wraps to 0.
  - `clr` or `load` zeroes `pre_cnt`.
  - `PRESCALE`=1 makes `pre_tick` = `en`.
- Undefined: no prescaler logic is present, the `PRESCALE` parameter is absent, and `step` = `en`.

## Structure
- `prog_counter_pkg` holds:
  - `W_MAX`=16;
  - the `count_dir_e` enum (`DIR_DOWN`=0, `DIR_UP`=1), used to decode `up`;
  - the `clamp_mod` function (0→1 modulus sanitisation), shared with future timer blocks.
- Sub-module `tick_prescaler` (clk, reset, en, sclr, tick) exists only under the macro.
- Top level holds `q`, `m_reg` and the next-state/output logic.

## Test plan
- Reset, then `up`=1, `en`=1 for 12 cycles with `M_RESET`=10: `q` goes 0..9,0,1. `co` and `max_tick` are high only in the cycle `q`=9.
- `up`=0 from `q`=0 with modulus 10: `q` goes 9,8,… and `co` is high in the `q`=0 cycle. `min_tick` tracks `q`=0.
- With `q`=7, write `m_in`=5, then step up: `q` becomes 0 with `co`=1. `m_in`=0 stores modulus 1, after which `q` stays 0 and `co` is high on every step.
- `load` with `d`=3 and `clr` together: `q`=0. `load` with `d`=12 at modulus 10: `q`=9. Neither cycle pulses `co`.
- With the macro and `PRESCALE`=4, hold `en`=1 continuously: `q` increments every 4th cycle. `clr` mid-period restarts the 4-cycle count.
- Two cascaded instances (modulus 10 and 6, `co`→`en`): the pair counts 0..59 and the upper `co` pulses once per 60 cycles. Asserting `reset` mid-run zeroes both within the same cycle.
